// File: rtl/instr_load_ctrl_if.sv
// Bus between the debug-unit byte stream, the load sequencer and instruction memory.
interface instr_load_ctrl_if #(
    parameter int unsigned ADDR_W = 5
) ();
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wr_instruction;
    logic [31:0]       inst_addr;
    logic [31:0]       data_instruction;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W:0]   word_count;

    // Sequencer side.
    modport slave (
        input  start, rx_data, rx_valid,
        output wr_instruction, inst_addr, data_instruction, cpu_hold, busy, done, overflow,
               word_count
    );

    // Debug-unit / environment side.
    modport master (
        output start, rx_data, rx_valid,
        input  wr_instruction, inst_addr, data_instruction, cpu_hold, busy, done, overflow,
               word_count
    );
endinterface

// File: rtl/instr_load_ctrl.sv
// Instruction-memory loader: packs 4 big-endian bytes per word and writes words at
// incrementing addresses until a HALT word or the last memory word, stalling the CPU meanwhile.
module instr_load_ctrl #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter logic [31:0] HALT   = 32'hFFFF_FFFF
) (
    input logic              clk,
    input logic              rst,
    instr_load_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [1:0]        byte_idx_q;
    logic [31:0]       shift_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   word_count_q;
    logic [31:0]       data_q;
    logic              wr_q;
    logic              hold_q;
    logic              busy_q;
    logic              done_q;
    logic              overflow_q;

    logic [31:0]       shift_next;

    // Shift register contents once the current byte is appended.
    assign shift_next = {shift_q[23:0], bus.rx_data};

    // Load sequencer; every output is a register so memory sees settled values on its negedge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            byte_idx_q   <= 2'd0;
            shift_q      <= 32'd0;
            addr_q       <= '0;
            word_count_q <= '0;
            data_q       <= 32'd0;
            wr_q         <= 1'b0;
            hold_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // Bytes arriving here are dropped; only start matters.
                    if (bus.start) begin
                        state_q      <= StCollect;
                        byte_idx_q   <= 2'd0;
                        shift_q      <= 32'd0;
                        addr_q       <= '0;
                        word_count_q <= '0;
                        overflow_q   <= 1'b0;
                        done_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        hold_q       <= 1'b1;
                    end
                end
                StCollect: begin
                    if (bus.rx_valid) begin
                        shift_q <= shift_next;
                        if (byte_idx_q == 2'd3) begin
                            byte_idx_q <= 2'd0;
                            data_q     <= shift_next;
                            wr_q       <= 1'b1;
                            state_q    <= StWrite;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
                StWrite: begin
                    wr_q         <= 1'b0;
                    word_count_q <= word_count_q + (ADDR_W + 1)'(1);
                    if (data_q == HALT || addr_q == LastAddr) begin
                        state_q    <= StDone;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        hold_q     <= 1'b0;
                        overflow_q <= (data_q != HALT);
                    end else begin
                        state_q <= StCollect;
                        addr_q  <= addr_q + ADDR_W'(1);
                        // A byte landing during the write cycle starts the next word.
                        if (bus.rx_valid) begin
                            shift_q    <= shift_next;
                            byte_idx_q <= 2'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.wr_instruction   = wr_q;
    assign bus.inst_addr        = {{(32 - ADDR_W){1'b0}}, addr_q};
    assign bus.data_instruction = data_q;
    assign bus.cpu_hold         = hold_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.overflow         = overflow_q;
    assign bus.word_count       = word_count_q;

endmodule

// File: tb/tb_instr_load_ctrl.sv
// Directed bench for instr_load_ctrl: byte streams in, logged memory writes checked.
module tb_instr_load_ctrl;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    instr_load_ctrl_if #(.ADDR_W(5)) bus ();

    instr_load_ctrl #(
        .DEPTH  (32),
        .ADDR_W (5),
        .HALT   (32'hFFFF_FFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_instruction) begin
            log_addr.push_back(bus.inst_addr);
            log_data.push_back(bus.data_instruction);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, " wr"},    32'(bus.wr_instruction),   32'd0);
        check_eq({tag, " addr"},  bus.inst_addr,             32'd0);
        check_eq({tag, " data"},  bus.data_instruction,      32'd0);
        check_eq({tag, " hold"},  32'(bus.cpu_hold),         32'd0);
        check_eq({tag, " busy"},  32'(bus.busy),             32'd0);
        check_eq({tag, " done"},  32'(bus.done),             32'd0);
        check_eq({tag, " ovf"},   32'(bus.overflow),         32'd0);
        check_eq({tag, " count"}, 32'(bus.word_count),       32'd0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // One byte, then one idle cycle; returns on the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    // Eight bytes on consecutive cycles, starting at the current negedge.
    task automatic send_stream8(input logic [63:0] v);
        for (int i = 0; i < 8; i++) begin
            bus.rx_data  = v[63 - 8 * i -: 8];
            bus.rx_valid = 1'b1;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.rx_data  = 8'd0;
        bus.rx_valid = 1'b0;
        idle_cycles(3);
        check_idle_zero("reset");
        rst = 1'b0;

        // Single word, observed during its write cycle.
        pulse_start();
        check_eq("t1 hold after start", 32'(bus.cpu_hold), 32'd1);
        send_word(32'h0022_1820);
        check_eq("t1 wr",   32'(bus.wr_instruction), 32'd1);
        check_eq("t1 addr", bus.inst_addr,           32'd0);
        check_eq("t1 data", bus.data_instruction,    32'h0022_1820);
        check_eq("t1 hold", 32'(bus.cpu_hold),       32'd1);
        check_eq("t1 busy", 32'(bus.busy),           32'd1);
        idle_cycles(1);
        check_eq("t1 wr one cycle", 32'(bus.wr_instruction), 32'd0);
        check_eq("t1 nwrites", 32'(log_addr.size()), 32'd1);

        // Three words ending in HALT.
        reset_dut();
        pulse_start();
        send_word(32'h1234_5678);
        send_word(32'h8C01_0004);
        send_word(32'hFFFF_FFFF);
        idle_cycles(2);
        check_eq("t2 nwrites", 32'(log_addr.size()), 32'd3);
        if (log_addr.size() == 3) begin
            check_eq("t2 addr0", log_addr[0], 32'd0);
            check_eq("t2 addr1", log_addr[1], 32'd1);
            check_eq("t2 addr2", log_addr[2], 32'd2);
            check_eq("t2 data0", log_data[0], 32'h1234_5678);
            check_eq("t2 data2", log_data[2], 32'hFFFF_FFFF);
        end
        check_eq("t2 done",  32'(bus.done),       32'd1);
        check_eq("t2 count", 32'(bus.word_count), 32'd3);
        check_eq("t2 ovf",   32'(bus.overflow),   32'd0);
        check_eq("t2 hold",  32'(bus.cpu_hold),   32'd0);
        check_eq("t2 busy",  32'(bus.busy),       32'd0);
        // Restart from DONE clears status.
        pulse_start();
        check_eq("t2 restart done",  32'(bus.done),       32'd0);
        check_eq("t2 restart busy",  32'(bus.busy),       32'd1);
        check_eq("t2 restart count", 32'(bus.word_count), 32'd0);

        // Fill all 32 words without HALT.
        reset_dut();
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            send_word({4{8'(i + 1)}});
        end
        idle_cycles(2);
        check_eq("t3 nwrites", 32'(log_addr.size()), 32'd32);
        if (log_addr.size() == 32) begin
            check_eq("t3 last addr", log_addr[31], 32'd31);
            check_eq("t3 last data", log_data[31], 32'h2020_2020);
            check_eq("t3 addr17",    log_addr[17], 32'd17);
        end
        check_eq("t3 done",  32'(bus.done),       32'd1);
        check_eq("t3 ovf",   32'(bus.overflow),   32'd1);
        check_eq("t3 count", 32'(bus.word_count), 32'd32);
        check_eq("t3 hold",  32'(bus.cpu_hold),   32'd0);
        send_word(32'h0102_0304);
        idle_cycles(2);
        check_eq("t3 no extra writes", 32'(log_addr.size()), 32'd32);

        // Byte arriving in the write cycle is kept.
        reset_dut();
        pulse_start();
        send_stream8(64'h1122_3344_ABCD_EF01);
        idle_cycles(2);
        check_eq("t4 nwrites", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check_eq("t4 data0",      log_data[0],        32'h1122_3344);
            check_eq("t4 addr1",      log_addr[1],        32'd1);
            check_eq("t4 data1 msb",  32'(log_data[1][31:24]), 32'h0000_00AB);
            check_eq("t4 data1",      log_data[1],        32'hABCD_EF01);
        end

        // Reset mid-load, then a fresh load starts at address 0.
        reset_dut();
        pulse_start();
        send_word(32'h0A0B_0C0D);
        send_word(32'h1A1B_1C1D);
        send_byte(8'h55);
        send_byte(8'h66);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("t5 rst");
        rst = 1'b0;
        log_addr.delete();
        log_data.delete();
        pulse_start();
        send_word(32'hDEAD_BEEF);
        idle_cycles(1);
        check_eq("t5 nwrites", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            check_eq("t5 addr", log_addr[0], 32'd0);
            check_eq("t5 data", log_data[0], 32'hDEAD_BEEF);
        end

        // Bytes in IDLE ignored; start during COLLECT ignored.
        reset_dut();
        send_word(32'h7777_7777);
        idle_cycles(1);
        check_eq("t6 idle nwrites", 32'(log_addr.size()), 32'd0);
        check_eq("t6 idle busy",    32'(bus.busy),        32'd0);
        pulse_start();
        send_byte(8'hC0);
        send_byte(8'hFF);
        pulse_start();
        check_eq("t6 busy after start", 32'(bus.busy), 32'd1);
        send_byte(8'hEE);
        send_byte(8'h11);
        idle_cycles(1);
        check_eq("t6 nwrites", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            check_eq("t6 addr", log_addr[0], 32'd0);
            check_eq("t6 data", log_data[0], 32'hC0FF_EE11);
        end
        check_eq("t6 count", 32'(bus.word_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
